instr_feeder: RTL and testbench

Program sequencer that sits directly upstream of the 16-bit multicycle processor. It holds a small program image and presents one instruction per processor cycle on `din`, pulsing `run` for one cycle. For move-immediate instructions it supplies the immediate word the following cycle, then waits for `done` before issuing the next instruction. The block replaces hand-driven `din`/`run` stimulus so the processor can execute stored programs on hardware and in simulation.

---
 rtl/instr_feeder.sv | 170 +++++++++++++++++
 tb/tb_instr_feeder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// instr_feeder: program sequencer feeding a 16-bit multicycle processor.
// Holds a small program image and issues one instruction per processor
// cycle on din with a one-cycle run pulse. mvi (opcode 001) is followed by
// its immediate word; HALT (opcode 111) is consumed here and stops issue.
//
// Handshake: run is a one-cycle valid pulse qualifying din; the processor
// has no back-pressure on run. done is the processor's completion flag and
// is only consumed in IMM and WAIT; it is ignored in IDLE, ISSUE and HALTED.
module instr_feeder #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic          done,
    output logic [15:0]   din,
    output logic          run,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          timeout_err,
    output logic [15:0]   icount,
    output logic [2:0]    dbg_state
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_IMM    = 3'd2,
        S_WAIT   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    logic [15:0]    mem_q [DEPTH];

    state_t         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [15:0]    icount_q, icount_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           terr_q, terr_d;
    logic           run_q, run_d;
    logic [15:0]    din_q, din_d;
    logic           mem_we;

    logic [15:0]    cur_word;
    logic [15:0]    nxt_word;

    // Word at the current pc decides ISSUE behaviour; word at the next pc
    // lets run/din be registered so they line up with the state they belong to.
    assign cur_word = mem_q[pc_q];
    assign nxt_word = mem_q[pc_d];

    // Next-state, counter and program-write decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        icount_d = icount_q;
        wcnt_d   = wcnt_q;
        terr_d   = terr_q;
        mem_we   = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                // A write in the same cycle as start wins; start is dropped.
                if (prog_we) begin
                    mem_we = 1'b1;
                end else if (start) begin
                    state_d  = S_ISSUE;
                    pc_d     = '0;
                    icount_d = '0;
                    terr_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (cur_word[15:13] == OP_HALT) begin
                    state_d = S_HALTED;
                end else begin
                    pc_d     = pc_q + 1'b1;
                    icount_d = icount_q + 16'd1;
                    wcnt_d   = '0;
                    state_d  = (cur_word[15:13] == OP_MVI) ? S_IMM : S_WAIT;
                end
            end
            S_IMM: begin
                pc_d = pc_q + 1'b1;
                if (done) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end
            end
            S_WAIT: begin
                if (done) begin
                    state_d = S_ISSUE;
                end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
                    state_d = S_HALTED;
                    terr_d  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered run/din values for the state being entered.
    always_comb begin
        run_d = 1'b0;
        din_d = '0;
        unique case (state_d)
            S_ISSUE: begin
                if (nxt_word[15:13] != OP_HALT) begin
                    run_d = 1'b1;
                    din_d = nxt_word;
                end
            end
            S_IMM:   din_d = nxt_word;
            S_WAIT:  din_d = din_q;
            default: din_d = '0;
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            icount_q <= '0;
            wcnt_q   <= '0;
            terr_q   <= 1'b0;
            run_q    <= 1'b0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            icount_q <= icount_d;
            wcnt_q   <= wcnt_d;
            terr_q   <= terr_d;
            run_q    <= run_d;
            din_q    <= din_d;
        end
    end

    // Program memory write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign din         = din_q;
    assign run         = run_q;
    assign pc          = pc_q;
    assign icount      = icount_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q == S_ISSUE) || (state_q == S_IMM) || (state_q == S_WAIT);
    assign halted      = (state_q == S_HALTED);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder with a behavioural processor that raises
// done three cycles after each run pulse.
module tb_instr_feeder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic        done = 1'b0;
  logic [15:0] din;
  logic        run;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
  logic        timeout_err;
  logic [15:0] icount;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] after_din_q[$];
  logic [4:0]  pc_after_q[$];

  instr_feeder #(.DEPTH(32), .AW(5), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .done(done),
    .din(din), .run(run), .pc(pc), .busy(busy), .halted(halted),
    .timeout_err(timeout_err), .icount(icount), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver tasks
  task automatic load_word(input logic [4:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Behavioural processor: done 3 cycles after each run. Stops on halted or
  // on the cycle after the stop_runs-th run (stop_runs = 0 disables that).
  task automatic run_model(input int max_cycles, input int stop_runs);
    int cd;
    int n;
    bit prev_run;
    bit prev_done;
    bit fin;
    bit dn;
    cd = -1; n = 0; prev_run = 0; prev_done = 0; fin = 0;
    got_q.delete(); after_din_q.delete(); pc_after_q.delete();
    for (int c = 0; c < max_cycles && !fin; c++) begin
      if (prev_run) begin
        after_din_q.push_back(din);
        pc_after_q.push_back(pc);
      end
      if (run === 1'b1) begin
        checks++;
        if (prev_run) begin
          errors++;
          $display("FAIL run_consecutive: run high two cycles in a row at cycle %0d", c);
        end
        if (n > 0) begin
          checks++;
          if (!prev_done) begin
            errors++;
            $display("FAIL run_after_done: run at cycle %0d without done in previous cycle", c);
          end
        end
        got_q.push_back(din);
        n++;
        cd = 3;
      end else if (cd > 0) begin
        cd--;
      end
      dn = (cd == 0);
      if (dn) cd = -1;
      fin = (halted === 1'b1) || (stop_runs > 0 && n >= stop_runs && run !== 1'b1);
      done = fin ? 1'b0 : dn;
      prev_done = done;
      prev_run = (run === 1'b1);
      if (!fin) tick();
    end
    done = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL model_budget: no stop within %0d cycles, runs=%0d", max_cycles, n);
    end
  endtask

  task automatic wait_halted(input int budget);
    int k;
    k = 0;
    while (halted !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL wait_halted: halted=%0b after %0d cycles, want 1", halted, budget);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({run, din, pc, busy, halted, timeout_err, icount, dbg_state} !== {1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: run=%0b din=%h pc=%0d busy=%0b halted=%0b terr=%0b icount=%0d state=%0d, want all 0",
               run, din, pc, busy, halted, timeout_err, icount, dbg_state);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || run !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%0b run=%0b, want 0 0", busy, run);
    end
  endtask

  task automatic test_program();
    load_word(5'd0, 16'h2000);
    load_word(5'd1, 16'h0005);
    load_word(5'd2, 16'h0400);
    load_word(5'd3, 16'h4080);
    load_word(5'd4, 16'h6000);
    load_word(5'd5, 16'hE000);
    exp_q = '{16'h2000, 16'h0400, 16'h4080, 16'h6000};
    pulse_start();
    run_model(200, 0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL prog_count: got %0d runs, want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL prog_din[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (after_din_q.size() < 1 || after_din_q[0] !== 16'h0005) begin
      errors++;
      $display("FAIL prog_imm: immediate after mvi got %h want 0005", after_din_q.size() > 0 ? after_din_q[0] : 16'hxxxx);
    end
    checks++;
    if ({halted, busy, timeout_err, pc, icount} !== {1'b1, 1'b0, 1'b0, 5'd5, 16'd4}) begin
      errors++;
      $display("FAIL prog_final: halted=%0b busy=%0b terr=%0b pc=%0d icount=%0d, want 1 0 0 5 4",
               halted, busy, timeout_err, pc, icount);
    end
  endtask

  task automatic test_timeout();
    load_word(5'd0, 16'h0400);
    done = 1'b0;
    pulse_start();
    checks++;
    if (run !== 1'b1 || din !== 16'h0400) begin
      errors++;
      $display("FAIL to_first_run: run=%0b din=%h, want 1 0400", run, din);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || halted !== 1'b0) begin
        errors++;
        $display("FAIL to_wait[%0d]: busy=%0b halted=%0b, want 1 0", i, busy, halted);
      end
    end
    tick();
    checks++;
    if ({halted, timeout_err, busy} !== 3'b110) begin
      errors++;
      $display("FAIL to_expire: halted=%0b terr=%0b busy=%0b, want 1 1 0", halted, timeout_err, busy);
    end
    pulse_start();
    checks++;
    if (timeout_err !== 1'b0 || pc !== 5'd0 || run !== 1'b1) begin
      errors++;
      $display("FAIL to_restart: terr=%0b pc=%0d run=%0b, want 0 0 1", timeout_err, pc, run);
    end
    wait_halted(20);
  endtask

  task automatic test_wrap();
    for (int a = 0; a < 32; a++) load_word(5'(a), 16'h0400);
    pulse_start();
    run_model(400, 40);
    checks++;
    if (got_q.size() != 40 || pc_after_q.size() != 40) begin
      errors++;
      $display("FAIL wrap_count: runs=%0d pcs=%0d, want 40 40", got_q.size(), pc_after_q.size());
    end else begin
      checks++;
      if (pc_after_q[30] !== 5'd31 || pc_after_q[31] !== 5'd0) begin
        errors++;
        $display("FAIL wrap_pc: pc after run 31/32 = %0d/%0d, want 31/0", pc_after_q[30], pc_after_q[31]);
      end
      checks++;
      if (pc_after_q[39] !== 5'd8) begin
        errors++;
        $display("FAIL wrap_pc40: got %0d want 8", pc_after_q[39]);
      end
    end
    checks++;
    if (icount !== 16'd40) begin
      errors++;
      $display("FAIL wrap_icount: got %0d want 40", icount);
    end
    wait_halted(20);
  endtask

  task automatic test_write_protect();
    load_word(5'd2, 16'hE000);
    pulse_start();
    prog_we = 1'b1; prog_addr = 5'd2; prog_data = 16'h4080;
    tick();
    tick();
    prog_we = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wp_busy: busy=%0b want 1", busy);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    run_model(60, 0);
    checks++;
    if ({halted, pc, icount} !== {1'b1, 5'd2, 16'd2} || got_q.size() != 1) begin
      errors++;
      $display("FAIL wp_ignored: halted=%0b pc=%0d icount=%0d runs=%0d, want 1 2 2 1", halted, pc, icount, got_q.size());
    end
    load_word(5'd2, 16'h4080);
    load_word(5'd3, 16'hE000);
    pulse_start();
    run_model(100, 0);
    checks++;
    if (got_q.size() != 3 || got_q[2] !== 16'h4080 || icount !== 16'd3 || pc !== 5'd3) begin
      errors++;
      $display("FAIL wp_halted_write: runs=%0d last=%h icount=%0d pc=%0d, want 3 4080 3 3",
               got_q.size(), got_q.size() > 0 ? got_q[got_q.size()-1] : 16'hxxxx, icount, pc);
    end
    prog_we = 1'b1; prog_addr = 5'd3; prog_data = 16'h6000; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    checks++;
    if ({halted, run, busy} !== 3'b100) begin
      errors++;
      $display("FAIL we_start_state: halted=%0b run=%0b busy=%0b, want 1 0 0", halted, run, busy);
    end
    tick();
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL we_start_hold: halted=%0b want 1", halted);
    end
    load_word(5'd4, 16'hE000);
    pulse_start();
    run_model(100, 0);
    checks++;
    if (got_q.size() != 4 || got_q[3] !== 16'h6000 || icount !== 16'd4) begin
      errors++;
      $display("FAIL we_start_write: runs=%0d last=%h icount=%0d, want 4 6000 4",
               got_q.size(), got_q.size() > 0 ? got_q[got_q.size()-1] : 16'hxxxx, icount);
    end
  endtask

  task automatic test_back_to_back();
    load_word(5'd0, 16'h2000);
    load_word(5'd1, 16'h0005);
    load_word(5'd2, 16'h0400);
    load_word(5'd3, 16'hE000);
    pulse_start();
    checks++;
    if (run !== 1'b1 || din !== 16'h2000) begin
      errors++;
      $display("FAIL b2b_issue: run=%0b din=%h, want 1 2000", run, din);
    end
    done = 1'b1;
    tick();
    checks++;
    if (run !== 1'b0 || din !== 16'h0005 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_imm: run=%0b din=%h busy=%0b, want 0 0005 1", run, din, busy);
    end
    tick();
    done = 1'b0;
    checks++;
    if (run !== 1'b1 || din !== 16'h0400 || pc !== 5'd2) begin
      errors++;
      $display("FAIL b2b_second: run=%0b din=%h pc=%0d, want 1 0400 2", run, din, pc);
    end
    tick();
    checks++;
    if (run !== 1'b0 || din !== 16'h0400) begin
      errors++;
      $display("FAIL b2b_wait_hold: run=%0b din=%h, want 0 0400", run, din);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (run !== 1'b0 || din !== 16'h0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_halt_issue: run=%0b din=%h busy=%0b, want 0 0000 1", run, din, busy);
    end
    tick();
    checks++;
    if ({halted, pc, icount, din} !== {1'b1, 5'd3, 16'd2, 16'h0000}) begin
      errors++;
      $display("FAIL b2b_final: halted=%0b pc=%0d icount=%0d din=%h, want 1 3 2 0000", halted, pc, icount, din);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    load_word(5'd0, 16'h0400);
    load_word(5'd1, 16'hE000);
    pulse_start();
    tick();
    checks++;
    if (din !== 16'h0400 || pc !== 5'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rm_pre: din=%h pc=%0d busy=%0b, want 0400 1 1", din, pc, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({run, din, busy, pc, icount, dbg_state} !== {1'b0, 16'h0, 1'b0, 5'd0, 16'd0, 3'd0}) begin
      errors++;
      $display("FAIL rm_async: run=%0b din=%h busy=%0b pc=%0d icount=%0d state=%0d, want all 0",
               run, din, busy, pc, icount, dbg_state);
    end
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      done = (i % 2 == 0);
      tick();
      if (run !== 1'b0 || busy !== 1'b0) bad++;
    end
    done = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rm_no_run: %0d cycles with run/busy after reset, want 0", bad);
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_program();
    test_timeout();
    test_wrap();
    test_write_protect();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
